// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM -> MEM/WB signal bundle for the memory stage.
// There is no handshake: the stage accepts one set of EX/MEM controls every
// cycle and presents the MEM/WB copy one rising edge later. pcsrc and
// branch_target are combinational views of the current EX/MEM inputs.
interface mem_stage_if;
    // EX/MEM side (driven by the previous pipeline register)
    logic [1:0]  wb_ctl_in;        // bit1 = regwrite, bit0 = memtoreg
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic [31:0] branch_target_in;
    logic        zero;
    logic [31:0] alu_result_in;    // byte address for data memory
    logic [31:0] wdata;
    logic [4:0]  write_reg_in;

    // Fetch-facing combinational outputs
    logic        pcsrc;
    logic [31:0] branch_target;

    // MEM/WB registered outputs
    logic [1:0]  wb_ctl_out;
    logic [31:0] read_data;
    logic [31:0] alu_result_out;
    logic [4:0]  write_reg_out;
    logic        misalign_err;

    // The memory stage itself
    modport slave (
        input  wb_ctl_in, branch, memread, memwrite, branch_target_in,
               zero, alu_result_in, wdata, write_reg_in,
        output pcsrc, branch_target, wb_ctl_out, read_data,
               alu_result_out, write_reg_out, misalign_err
    );

    // Whoever drives the EX/MEM side and consumes MEM/WB
    modport master (
        output wb_ctl_in, branch, memread, memwrite, branch_target_in,
               zero, alu_result_in, wdata, write_reg_in,
        input  pcsrc, branch_target, wb_ctl_out, read_data,
               alu_result_out, write_reg_out, misalign_err
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: 256 x 32 data memory (1 KiB byte space, wraps),
// combinational read with read-before-write, MEM/WB pipeline register,
// branch select to fetch and a sticky misaligned-access flag.
module mem_stage (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave bus
);
    localparam int unsigned DEPTH = 256;

    // Memory powers up cleared; reset deliberately leaves it alone.
    logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

    logic [1:0]  wb_ctl_q     = 2'b00;
    logic [31:0] read_data_q  = 32'h0;
    logic [31:0] alu_result_q = 32'h0;
    logic [4:0]  write_reg_q  = 5'd0;
    logic        misalign_q   = 1'b0;

    logic [7:0]  mem_idx;
    logic [31:0] read_data_d;
    logic        misalign_d;

    // Word index: address bits above 9 are dropped, low two bits ignored.
    assign mem_idx = bus.alu_result_in[9:2];

    // Read data and sticky misalignment for the next MEM/WB load.
    always_comb begin
        read_data_d = 32'h0;
        if (bus.memread) begin
            read_data_d = mem_q[mem_idx];
        end
        misalign_d = misalign_q
                   | ((bus.memread | bus.memwrite)
                      & (bus.alu_result_in[1:0] != 2'b00));
    end

    // Store port; non-blocking update makes a same-cycle read see the old word.
    always_ff @(posedge clk) begin
        if (!rst && bus.memwrite) begin
            mem_q[mem_idx] <= bus.wdata;
        end
    end

    // MEM/WB pipeline register and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ctl_q     <= 2'b00;
            read_data_q  <= 32'h0;
            alu_result_q <= 32'h0;
            write_reg_q  <= 5'd0;
            misalign_q   <= 1'b0;
        end else begin
            wb_ctl_q     <= bus.wb_ctl_in;
            read_data_q  <= read_data_d;
            alu_result_q <= bus.alu_result_in;
            write_reg_q  <= bus.write_reg_in;
            misalign_q   <= misalign_d;
        end
    end

    // Branch decision is unregistered and not gated by reset.
    assign bus.pcsrc          = bus.branch & bus.zero;
    assign bus.branch_target  = bus.branch_target_in;

    assign bus.wb_ctl_out     = wb_ctl_q;
    assign bus.read_data      = read_data_q;
    assign bus.alu_result_out = alu_result_q;
    assign bus.write_reg_out  = write_reg_q;
    assign bus.misalign_err   = misalign_q;
endmodule
